reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's 3-read/1-write register file: configurable data width and depth, separate write address, optional write-to-read bypass, hardware clear sweep after reset, and a per-register busy scoreboard for the pipelined CPU.
- Sits between decode (three reads plus scoreboard query) and writeback (one write). The debug read port feeds the board's register viewer.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width. DEPTH = 2**ADDR_W entries (localparam).
- ZERO_REG, 1: 1 hardwires entry 0 to zero and never marks it busy.
- BYPASS, 1: 1 forwards the same-cycle write data to matching read ports.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rf_ready  out  1  high when the clear sweep is done and the file is usable.
- rf_ra_k  in  ADDR_W  read address k.
- rf_ra_j  in  ADDR_W  read address j.
- rf_ra_d  in  ADDR_W  read address d.
- rf_rd_k  out  DATA_W  read data k, combinational.
- rf_rd_j  out  DATA_W  read data j, combinational.
- rf_rd_d  out  DATA_W  read data d, combinational.
- rf_we  in  1  write enable.
- rf_wa  in  ADDR_W  write address.
- rf_wd  in  DATA_W  write data.
- sb_set  in  1  mark register sb_set_a as pending (issued producer).
- sb_set_a  in  ADDR_W  scoreboard set address.
- rf_busy_k  out  1  busy bit of rf_ra_k, combinational.
- rf_busy_j  out  1  busy bit of rf_ra_j, combinational.
- rf_busy_d  out  1  busy bit of rf_ra_d, combinational.
- dbg_reg_ra  in  ADDR_W  debug read address.
- dbg_reg_rd  out  DATA_W  debug read data, no bypass applied.

Behaviour:
- State machine has two states, CLEAR and READY. rst=1 at an edge sets state=CLEAR, clr_idx=0 and all busy bits to 0, and holds clr_idx at 0 while rst stays high.
- CLEAR with rst=0: each edge writes 0 to entry clr_idx and increments clr_idx. The edge that clears entry DEPTH-1 moves the state to READY.
- rf_ready=0 in CLEAR. It rises exactly DEPTH edges after the first edge with rst low (32 for the default ADDR_W).
- rst asserted mid-sweep restarts the sweep at entry 0.
- Power-up state is undefined. Integration must assert rst before use.
- In CLEAR: rf_rd_*, dbg_reg_rd and rf_busy_* are forced to 0, and rf_we and sb_set are ignored.
- Write (READY): rf_we=1 writes rf_wd to entry rf_wa at the edge; the value is visible on reads from the next cycle. ZERO_REG=1 with rf_wa=0 discards the write.
- Reads are asynchronous. ZERO_REG=1 with address 0 always returns 0.
- Bypass with BYPASS=1: if rf_we=1, READY, rf_wa equals the read address, and rf_wa is nonzero (or ZERO_REG=0), that read port returns rf_wd in the same cycle.
- BYPASS=0: the read returns the stored value.
- The debug port never bypasses.
- Scoreboard (READY):
  - rf_we=1 clears busy[rf_wa] at the edge.
  - sb_set=1 sets busy[sb_set_a] at the edge.
  - Set and clear on the same address in the same cycle: set wins, busy stays 1 (new producer issued).
  - Set and clear on different addresses both take effect.
  - ZERO_REG=1: busy[0] stays 0 and setting it is ignored.
  - rf_busy_* reflect registered bits only and are not bypassed by a same-cycle write.
- Width rules: all arithmetic is on ADDR_W bits, and clr_idx wraps only through the DEPTH-1 terminal check. No width extension of data is performed.

Test Plan:
- Reset sweep: preload entries 5=0xDEADBEEF and 31=0x1 via writes, assert rst for 2 cycles, release -> rf_ready=0 for 32 cycles, then 1; reads of 5 and 31 return 0.
- Write/read: READY, write r7=0x12345678 -> rf_rd_j(ra=7)=0x12345678 the next cycle; write r0=0xFFFFFFFF -> rf_rd_k(ra=0)=0.
- Bypass: same-cycle rf_we=1, rf_wa=9, rf_wd=0xA5A5A5A5, rf_ra_d=9 -> rf_rd_d=0xA5A5A5A5 that cycle and dbg_reg_rd(ra=9) shows the old value. Repeat with BYPASS=0 -> rf_rd_d shows the old value.
- Scoreboard:
  - sb_set on r3 -> rf_busy_k(ra=3)=1 the next cycle.
  - rf_we on r3 -> busy=0 the next cycle.
  - Simultaneous sb_set r3 and rf_we r3 -> busy stays 1.
  - sb_set on r0 -> busy stays 0.
- Reset mid-sweep: assert rst at sweep cycle 10 for 1 cycle -> rf_ready rises 32 cycles after release; a write attempted during CLEAR (r4=0x55) leaves r4=0 after ready.
- Parametrisation: DATA_W=64, ADDR_W=3 -> rf_ready after 8 cycles; write r7=0x0123456789ABCDEF reads back intact.

Source files
------------

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Parametrised 3-read / 1-write register file with a debug read
//             port, optional same-cycle write-to-read bypass, a hardware
//             clear sweep after reset and a per-register busy scoreboard.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             rf_ready           - high once the clear sweep has finished
//             rf_ra_{k,j,d}      - read addresses
//             rf_rd_{k,j,d}      - combinational read data (optional bypass)
//             rf_we/rf_wa/rf_wd  - writeback port; a write also clears busy
//             sb_set/sb_set_a    - mark a register as having a producer
//             rf_busy_{k,j,d}    - registered busy bit of each read address
//             dbg_reg_ra/_rd     - debug read port, never bypassed
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rf_ready,
  input  logic [ADDR_W-1:0] rf_ra_k,
  input  logic [ADDR_W-1:0] rf_ra_j,
  input  logic [ADDR_W-1:0] rf_ra_d,
  output logic [DATA_W-1:0] rf_rd_k,
  output logic [DATA_W-1:0] rf_rd_j,
  output logic [DATA_W-1:0] rf_rd_d,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_wa,
  input  logic [DATA_W-1:0] rf_wd,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_set_a,
  output logic              rf_busy_k,
  output logic              rf_busy_j,
  output logic              rf_busy_d,
  input  logic [ADDR_W-1:0] dbg_reg_ra,
  output logic [DATA_W-1:0] dbg_reg_rd
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NRD   = 3;

  localparam logic [ADDR_W-1:0] c_last_idx = '1;
  localparam logic [ADDR_W-1:0] c_idx_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_ready;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic [DEPTH-1:0]    r_busy;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_in_ready;
  logic                w_wa_zero;
  logic                w_set_zero;
  logic                w_wr_ok;
  logic                w_set_ok;
  logic                w_dbg_zero;
  logic [NRD*ADDR_W-1:0] w_ra_flat;
  logic [NRD*DATA_W-1:0] w_rd_flat;
  logic [NRD-1:0]        w_busy_flat;

  assign w_in_ready = (r_state == ST_READY);

  // Entry 0 is a constant zero when ZERO_REG is set: writes to it are
  // dropped and it can never gain a producer.
  assign w_wa_zero  = (ZERO_REG != 0) && (rf_wa == '0);
  assign w_set_zero = (ZERO_REG != 0) && (sb_set_a == '0);
  assign w_dbg_zero = (ZERO_REG != 0) && (dbg_reg_ra == '0);

  // A write only lands (and is only forwarded) once the sweep is done.
  assign w_wr_ok  = w_in_ready && rf_we && !w_wa_zero;
  assign w_set_ok = sb_set && !w_set_zero;

  // --------------------------------------------------------------------------
  // Control FSM: clear sweep, ready flag and busy scoreboard.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_ready   <= 1'b0;
      r_clr_idx <= '0;
      r_busy    <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + c_idx_one;
          if (r_clr_idx == c_last_idx) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: begin
          // Clear first, then set: a new producer issued in the same cycle
          // as the old result retires keeps the register busy.
          if (rf_we) begin
            r_busy[rf_wa] <= 1'b0;
          end
          if (w_set_ok) begin
            r_busy[sb_set_a] <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage. No reset term so the array can map onto plain registers or
  // RAM; the sweep zeroes one entry per cycle instead.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_in_ready) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_ok) begin
        r_mem[rf_wa] <= rf_wd;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  assign w_ra_flat = {rf_ra_d, rf_ra_j, rf_ra_k};

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_port
    logic [ADDR_W-1:0] w_ra;
    logic              w_ra_zero;
    logic              w_byp_hit;

    assign w_ra      = w_ra_flat[gi*ADDR_W +: ADDR_W];
    assign w_ra_zero = (ZERO_REG != 0) && (w_ra == '0);
    // w_wr_ok already excludes the hardwired-zero entry, so a write to r0
    // is never forwarded.
    assign w_byp_hit = (BYPASS != 0) && w_wr_ok && (rf_wa == w_ra);

    assign w_rd_flat[gi*DATA_W +: DATA_W] =
        (!w_in_ready || w_ra_zero) ? '0 :
        (w_byp_hit ? rf_wd : r_mem[w_ra]);

    // Busy reflects the registered scoreboard only; a same-cycle write is
    // not treated as having released the register yet.
    assign w_busy_flat[gi] = w_in_ready && r_busy[w_ra];
  end : g_rd_port

  assign rf_rd_k   = w_rd_flat[0*DATA_W +: DATA_W];
  assign rf_rd_j   = w_rd_flat[1*DATA_W +: DATA_W];
  assign rf_rd_d   = w_rd_flat[2*DATA_W +: DATA_W];
  assign rf_busy_k = w_busy_flat[0];
  assign rf_busy_j = w_busy_flat[1];
  assign rf_busy_d = w_busy_flat[2];

  // Debug port always shows the stored contents.
  assign dbg_reg_rd = (!w_in_ready || w_dbg_zero) ? '0 : r_mem[dbg_reg_ra];

  assign rf_ready = r_ready;

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Purpose  : Self-checking bench for reg_file_sb. Instance A uses default
//             parameters, instance B shares A's inputs with BYPASS=0, and
//             instance C is a 64-bit x 8-entry build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A / B stimulus ----------------
  logic        rst, we, sb_set;
  logic [4:0]  ra_k, ra_j, ra_d, wa, sb_set_a, dbg_ra;
  logic [31:0] wd;

  logic        ready_a, bk_a, bj_a, bd_a;
  logic [31:0] rdk_a, rdj_a, rdd_a, dbg_a;
  logic        ready_b, bk_b, bj_b, bd_b;
  logic [31:0] rdk_b, rdj_b, rdd_b, dbg_b;

  // ---------------- instance C stimulus ----------------
  logic        rst_c, we_c, set_c;
  logic [2:0]  rak_c, raj_c, rad_c, wa_c, seta_c, dbgra_c;
  logic [63:0] wd_c;
  logic        ready_c, bk_c, bj_c, bd_c;
  logic [63:0] rdk_c, rdj_c, rdd_c, dbg_c;

  reg_file_sb u_a (
    .clk(clk), .rst(rst), .rf_ready(ready_a),
    .rf_ra_k(ra_k), .rf_ra_j(ra_j), .rf_ra_d(ra_d),
    .rf_rd_k(rdk_a), .rf_rd_j(rdj_a), .rf_rd_d(rdd_a),
    .rf_we(we), .rf_wa(wa), .rf_wd(wd),
    .sb_set(sb_set), .sb_set_a(sb_set_a),
    .rf_busy_k(bk_a), .rf_busy_j(bj_a), .rf_busy_d(bd_a),
    .dbg_reg_ra(dbg_ra), .dbg_reg_rd(dbg_a)
  );

  reg_file_sb #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rf_ready(ready_b),
    .rf_ra_k(ra_k), .rf_ra_j(ra_j), .rf_ra_d(ra_d),
    .rf_rd_k(rdk_b), .rf_rd_j(rdj_b), .rf_rd_d(rdd_b),
    .rf_we(we), .rf_wa(wa), .rf_wd(wd),
    .sb_set(sb_set), .sb_set_a(sb_set_a),
    .rf_busy_k(bk_b), .rf_busy_j(bj_b), .rf_busy_d(bd_b),
    .dbg_reg_ra(dbg_ra), .dbg_reg_rd(dbg_b)
  );

  reg_file_sb #(.DATA_W(64), .ADDR_W(3)) u_c (
    .clk(clk), .rst(rst_c), .rf_ready(ready_c),
    .rf_ra_k(rak_c), .rf_ra_j(raj_c), .rf_ra_d(rad_c),
    .rf_rd_k(rdk_c), .rf_rd_j(rdj_c), .rf_rd_d(rdd_c),
    .rf_we(we_c), .rf_wa(wa_c), .rf_wd(wd_c),
    .sb_set(set_c), .sb_set_a(seta_c),
    .rf_busy_k(bk_c), .rf_busy_j(bj_c), .rf_busy_d(bd_c),
    .dbg_reg_ra(dbgra_c), .dbg_reg_rd(dbg_c)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instances A and B) ----------------
  // The sweep is modelled as a countdown of edges with rst low; when it
  // completes the whole array is zero, since nothing can be written or
  // observed while it runs.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          m_cnt   = 0;
  bit          m_valid = 0;

  function automatic bit m_ready();
    return (m_cnt == 32);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (!m_ready() || a == 0) return 32'h0;
    if (byp && we && wa == a && wa != 0) return wd;
    return m_mem[a];
  endfunction

  function automatic bit m_bsy(input logic [4:0] a);
    return m_ready() && m_busy[a];
  endfunction

  task automatic model_update();
    if (rst) begin
      m_valid = 1;
      m_cnt   = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else if (m_cnt < 32) begin
      m_cnt++;
      if (m_cnt == 32) foreach (m_mem[i]) m_mem[i] = 32'h0;
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (we) m_busy[wa] = 0;
      if (sb_set && sb_set_a != 0) m_busy[sb_set_a] = 1;
    end
  endtask

  task automatic check_all();
    if (!m_valid) return;
    chk("ready_a", ready_a, m_ready());
    chk("rd_k_a",  rdk_a,   m_read(ra_k, 1));
    chk("rd_j_a",  rdj_a,   m_read(ra_j, 1));
    chk("rd_d_a",  rdd_a,   m_read(ra_d, 1));
    chk("dbg_a",   dbg_a,   m_read(dbg_ra, 0));
    chk("busy_k_a", bk_a,   m_bsy(ra_k));
    chk("busy_j_a", bj_a,   m_bsy(ra_j));
    chk("busy_d_a", bd_a,   m_bsy(ra_d));
    chk("ready_b", ready_b, m_ready());
    chk("rd_k_b",  rdk_b,   m_read(ra_k, 0));
    chk("rd_j_b",  rdj_b,   m_read(ra_j, 0));
    chk("rd_d_b",  rdd_b,   m_read(ra_d, 0));
    chk("dbg_b",   dbg_b,   m_read(dbg_ra, 0));
    chk("busy_k_b", bk_b,   m_bsy(ra_k));
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are sampled
  // 2 units later, well before the next rising edge.
  task automatic step_pre();
    #2;
    check_all();
  endtask

  task automatic step_post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    step_pre();
    step_post();
  endtask

  task automatic idle();
    rst = 0; we = 0; sb_set = 0;
  endtask

  task automatic count_ready(input string nm);
    int n = 0;
    while (!ready_a && n < 200) begin
      tick();
      n++;
    end
    chk(nm, n, 32);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        set;
    logic [4:0]  sa, rak, raj, rad, dbg;
    logic [31:0] e_k, e_j, e_d, e_dbg, e_d_nb;
    logic        e_bk, e_bj;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Starting from a freshly swept file (all zero, nothing busy).
    tbl[0]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd7,
                32'h0, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7,
                32'h0, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0,
                32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3, 5'd7, 5'd9, 5'd9,
                32'h0, 32'h12345678, 32'hA5A5A5A5, 32'h11111111, 32'h11111111, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 5'd9, 5'd9,
                32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd0, 5'd9, 5'd3,
                32'h33, 32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3,
                32'h44, 32'h44, 32'h0, 32'h33, 32'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3,
                32'h44, 32'h0, 32'h0, 32'h44, 32'h0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 5'd0, 5'd6, 5'd6, 5'd0,
                32'h0, 32'h66, 32'h66, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6, 5'd6, 5'd6,
                32'h0, 32'h66, 32'h66, 32'h66, 32'h66, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd5, 32'hF, 1'b1, 5'd6, 5'd5, 5'd6, 5'd5, 5'd5,
                32'hF, 32'h66, 32'hF, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd5,
                32'hF, 32'h66, 32'h0, 32'hF, 32'h0, 1'b0, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1; we = 0; sb_set = 0; wa = 0; wd = 0; sb_set_a = 0;
    ra_k = 0; ra_j = 0; ra_d = 0; dbg_ra = 0;
    rst_c = 1; we_c = 0; set_c = 0; wa_c = 0; wd_c = 0; seta_c = 0;
    rak_c = 0; raj_c = 0; rad_c = 0; dbgra_c = 0;

    // Initial reset and sweep.
    tick();
    tick();
    idle();
    count_ready("sweep_len_initial");

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      sb_set = tbl[i].set; sb_set_a = tbl[i].sa;
      ra_k = tbl[i].rak; ra_j = tbl[i].raj; ra_d = tbl[i].rad; dbg_ra = tbl[i].dbg;
      step_pre();
      chk($sformatf("tbl%0d_rd_k", i),  rdk_a, tbl[i].e_k);
      chk($sformatf("tbl%0d_rd_j", i),  rdj_a, tbl[i].e_j);
      chk($sformatf("tbl%0d_rd_d", i),  rdd_a, tbl[i].e_d);
      chk($sformatf("tbl%0d_dbg", i),   dbg_a, tbl[i].e_dbg);
      chk($sformatf("tbl%0d_rd_d_nobyp", i), rdd_b, tbl[i].e_d_nb);
      chk($sformatf("tbl%0d_busy_k", i), bk_a, tbl[i].e_bk);
      chk($sformatf("tbl%0d_busy_j", i), bj_a, tbl[i].e_bj);
      step_post();
    end
    idle();

    // Reset sweep wipes previously written data.
    we = 1; wa = 5;  wd = 32'hDEADBEEF; tick();
    we = 1; wa = 31; wd = 32'h1;        tick();
    we = 0; ra_k = 5; ra_j = 31;
    step_pre();
    chk("preload_r5",  rdk_a, 32'hDEADBEEF);
    chk("preload_r31", rdj_a, 32'h1);
    step_post();
    rst = 1; tick(); tick();
    rst = 0;
    step_pre();
    chk("ready_low_after_rst", ready_a, 1'b0);
    step_post();
    begin
      int n = 1;
      while (!ready_a && n < 200) begin tick(); n++; end
      chk("sweep_len_after_preload", n, 32);
    end
    step_pre();
    chk("swept_r5",  rdk_a, 32'h0);
    chk("swept_r31", rdj_a, 32'h0);
    step_post();

    // Reset in the middle of a sweep; a write during CLEAR is ignored.
    rst = 1; tick();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      we = (i == 3); wa = 4; wd = 32'h55;
      tick();
    end
    we = 0;
    rst = 1; tick();
    rst = 0;
    count_ready("sweep_len_mid_rst");
    ra_k = 4;
    step_pre();
    chk("clear_write_ignored", rdk_a, 32'h0);
    step_post();

    // 64-bit x 8 build.
    tick();
    rst_c = 0;
    begin
      int n = 0;
      while (!ready_c && n < 200) begin tick(); n++; end
      chk("c_sweep_len", n, 8);
    end
    we_c = 1; wa_c = 7; wd_c = 64'h0123456789ABCDEF; rak_c = 7; dbgra_c = 7;
    #2;
    chk("c_bypass_rd_k", rdk_c, 64'h0123456789ABCDEF);
    chk("c_dbg_old",     dbg_c, 64'h0);
    tick();
    we_c = 0; raj_c = 7; rad_c = 0;
    #2;
    chk("c_rd_j_r7", rdj_c, 64'h0123456789ABCDEF);
    chk("c_dbg_r7",  dbg_c, 64'h0123456789ABCDEF);
    chk("c_rd_d_r0", rdd_c, 64'h0);
    tick();

    // Randomized traffic against the model. Narrow address ranges are used
    // part of the time to provoke collisions between ports.
    for (int i = 0; i < 3000; i++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 1) == 1);
      rst      = ($urandom_range(0, 399) == 0);
      we       = $urandom_range(0, 1);
      sb_set   = ($urandom_range(0, 2) == 0);
      wd       = $urandom;
      wa       = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      sb_set_a = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra_k     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra_j     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra_d     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      dbg_ra   = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_reg_file_sb
`default_nettype wire
